// File: rtl/m10k_row_packer_pkg.sv
// Shared types and default geometry for the M10K row packer.
package m10k_row_packer_pkg;

    localparam int unsigned DATA_LEN_DEF     = 8;
    localparam int unsigned M_DEF            = 8;
    localparam int unsigned ADDRESS_SIZE_DEF = 10;
    localparam int unsigned NUM_ROWS_DEF     = 12;
    localparam int unsigned OFFSET_DEF       = 0;

    // Bank offsets used as OFFSET by the three instances (weights, fmap B, fmap C).
    localparam int unsigned READ_A_ADDR_OFFSET = 0;
    localparam int unsigned READ_B_ADDR_OFFSET = 0;
    localparam int unsigned READ_C_ADDR_OFFSET = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/m10k_row_packer.sv
// Packs a byte-serial valid/ready stream into ROW_SIZE-bit SRAM rows and
// writes NUM_ROWS consecutive rows starting at OFFSET, then pulses o_done.
// Optional feature macro: PACKER_EARLY_LAST_EN (i_in_last closes a row early).
module m10k_row_packer
    import m10k_row_packer_pkg::*;
#(
    parameter int unsigned DATA_LEN     = DATA_LEN_DEF,
    parameter int unsigned M            = M_DEF,
    parameter int unsigned ROW_SIZE     = DATA_LEN * M,
    parameter int unsigned ADDRESS_SIZE = ADDRESS_SIZE_DEF,
    parameter int unsigned NUM_ROWS     = NUM_ROWS_DEF,
    parameter int unsigned OFFSET       = OFFSET_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load_start,
    input  logic                    i_in_valid,
    input  logic [DATA_LEN-1:0]     i_in_data,
    input  logic                    i_in_last,
    output logic                    o_in_ready,
    output logic [ADDRESS_SIZE-1:0] o_address,
    output logic                    o_wr_en,
    output logic [ROW_SIZE-1:0]     o_write_data,
    output logic [1:0]              o_state,
    output logic [ADDRESS_SIZE-1:0] o_row_cnt,
    output logic                    o_done
);

    localparam int unsigned LANE_W = (M > 1) ? $clog2(M) : 1;
    localparam logic [LANE_W-1:0]       LAST_LANE  = LANE_W'(M - 1);
    localparam logic [ADDRESS_SIZE-1:0] BASE_ADDR  = ADDRESS_SIZE'(OFFSET);
    localparam logic [ADDRESS_SIZE-1:0] ROW_TARGET = ADDRESS_SIZE'(NUM_ROWS);

    state_e                  state_q;
    logic [LANE_W-1:0]       lane_q;
    logic [ROW_SIZE-1:0]     row_q;
    logic [ADDRESS_SIZE-1:0] row_cnt_q;
    logic                    in_ready_q;
    logic                    wr_en_q;
    logic [ADDRESS_SIZE-1:0] address_q;
    logic                    done_q;

    logic                    hs_c;
    logic                    row_end_c;
    logic [ADDRESS_SIZE-1:0] row_cnt_inc_c;

    // Handshake only exists while in FILL, since ready is high only there.
    assign hs_c          = i_in_valid && in_ready_q;
    assign row_cnt_inc_c = row_cnt_q + ADDRESS_SIZE'(1);

`ifdef PACKER_EARLY_LAST_EN
    // A row closes on its last lane or on an early terminator.
    assign row_end_c = (lane_q == LAST_LANE) || i_in_last;
`else
    // Rows are always exactly M words; the terminator is not used.
    logic unused_last_c;
    assign unused_last_c = i_in_last;
    assign row_end_c     = (lane_q == LAST_LANE);
`endif

    // Load FSM with lane counter, row register and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            lane_q     <= '0;
            row_q      <= '0;
            row_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            address_q  <= BASE_ADDR;
            done_q     <= 1'b0;
        end else begin
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            address_q  <= BASE_ADDR;
            done_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    lane_q <= '0;
                    row_q  <= '0;
                    if (i_load_start) begin
                        state_q    <= ST_FILL;
                        row_cnt_q  <= '0;
                        in_ready_q <= 1'b1;
                    end
                end
                ST_FILL: begin
                    in_ready_q <= 1'b1;
                    if (hs_c) begin
                        row_q[DATA_LEN*lane_q +: DATA_LEN] <= i_in_data;
                        lane_q <= lane_q + LANE_W'(1);
                        if (row_end_c) begin
                            state_q    <= ST_WRITE;
                            in_ready_q <= 1'b0;
                            wr_en_q    <= 1'b1;
                            address_q  <= BASE_ADDR + row_cnt_q;
                        end
                    end
                end
                ST_WRITE: begin
                    lane_q    <= '0;
                    row_cnt_q <= row_cnt_inc_c;
                    if (row_cnt_inc_c == ROW_TARGET) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= ST_FILL;
                        row_q      <= '0;
                        in_ready_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    lane_q  <= '0;
                    row_q   <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_state      = state_q;
    assign o_in_ready   = in_ready_q;
    assign o_wr_en      = wr_en_q;
    assign o_address    = address_q;
    assign o_write_data = row_q;
    assign o_row_cnt    = row_cnt_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_m10k_row_packer.sv
// Bench for m10k_row_packer: transaction-level reference model plus
// directed loads, randomized traffic and a second full-size instance.
module tb_m10k_row_packer;

    localparam int unsigned DL   = 8;
    localparam int unsigned MM   = 8;
    localparam int unsigned ROW  = DL * MM;
    localparam int unsigned AS   = 10;
    localparam int unsigned NR   = 2;
    localparam int unsigned OFS  = 16;
    localparam int unsigned NR_B = 12;
`ifdef PACKER_EARLY_LAST_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A stimulus and outputs.
    logic           rst = 1'b1;
    logic           load_start = 1'b0;
    logic           valid = 1'b0;
    logic [DL-1:0]  data = '0;
    logic           last = 1'b0;
    logic           ready;
    logic [AS-1:0]  address;
    logic           wr_en;
    logic [ROW-1:0] wdata;
    logic [1:0]     state;
    logic [AS-1:0]  row_cnt;
    logic           done;

    // Instance B stimulus and outputs.
    logic           start_b = 1'b0;
    logic           valid_b = 1'b0;
    logic [DL-1:0]  data_b = '0;
    logic           last_b = 1'b0;
    logic           ready_b;
    logic [AS-1:0]  address_b;
    logic           wr_en_b;
    logic [ROW-1:0] wdata_b;
    logic [1:0]     state_b;
    logic [AS-1:0]  row_cnt_b;
    logic           done_b;

    m10k_row_packer #(
        .DATA_LEN(DL), .M(MM), .ROW_SIZE(ROW), .ADDRESS_SIZE(AS),
        .NUM_ROWS(NR), .OFFSET(OFS)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_load_start(load_start),
        .i_in_valid(valid), .i_in_data(data), .i_in_last(last),
        .o_in_ready(ready), .o_address(address), .o_wr_en(wr_en),
        .o_write_data(wdata), .o_state(state), .o_row_cnt(row_cnt),
        .o_done(done)
    );

    m10k_row_packer #(
        .DATA_LEN(DL), .M(MM), .ROW_SIZE(ROW), .ADDRESS_SIZE(AS),
        .NUM_ROWS(NR_B), .OFFSET(0)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_load_start(start_b),
        .i_in_valid(valid_b), .i_in_data(data_b), .i_in_last(last_b),
        .o_in_ready(ready_b), .o_address(address_b), .o_wr_en(wr_en_b),
        .o_write_data(wdata_b), .o_state(state_b), .o_row_cnt(row_cnt_b),
        .o_done(done_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ROW-1:0] pack_q(input logic [DL-1:0] q[$]);
        logic [ROW-1:0] r;
        r = '0;
        foreach (q[i]) r[DL*i +: DL] = q[i];
        return r;
    endfunction

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    // Reference model: a load is "active" from start until its last row is
    // written; a row is the list of accepted bytes; a written row is visible
    // for one cycle, and the final one is followed by a one-cycle done.
    bit             m_active = 1'b0;
    bit             m_wr = 1'b0;
    bit             m_done = 1'b0;
    int             m_rows = 0;
    logic [DL-1:0]  m_row[$];
    logic [ROW-1:0] m_full = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0; m_wr = 1'b0; m_done = 1'b0; m_rows = 0;
            m_row.delete(); m_full = '0;
        end else if (m_wr) begin
            m_wr = 1'b0;
            m_rows++;
            m_row.delete();
            if (m_rows == NR) begin
                m_active = 1'b0;
                m_done = 1'b1;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (!m_active) begin
            if (load_start) begin
                m_active = 1'b1;
                m_rows = 0;
            end
        end else if (valid) begin
            m_row.push_back(data);
            if (m_row.size() == MM || (EARLY && last)) begin
                m_wr = 1'b1;
                m_full = pack_q(m_row);
            end
        end
    end

    // Per-cycle compare of instance A against the model, plus write/done log.
    logic [AS-1:0]  wlog_addr[$];
    logic [ROW-1:0] wlog_data[$];
    bit             done_seen = 1'b0;
    int             done_diff = 0;
    logic [AS-1:0]  done_rowcnt = '0;
    int             s_edge = 0;

    always @(negedge clk) begin
        logic [1:0] exp_state;
        exp_state = m_done ? 2'd3 : (m_wr ? 2'd2 : (m_active ? 2'd1 : 2'd0));
        check("ready",   64'(ready),   64'(m_active && !m_wr));
        check("wr_en",   64'(wr_en),   64'(m_wr));
        check("address", 64'(address), m_wr ? 64'(OFS + m_rows) : 64'(OFS));
        check("wdata",   64'(wdata),   (m_wr || m_done) ? 64'(m_full) : 64'(pack_q(m_row)));
        check("state",   64'(state),   64'(exp_state));
        check("row_cnt", 64'(row_cnt), 64'(m_rows));
        check("done",    64'(done),    64'(m_done));
        if (wr_en) begin
            wlog_addr.push_back(address);
            wlog_data.push_back(wdata);
        end
        if (done) begin
            done_seen   = 1'b1;
            done_diff   = edge_cnt + 1 - s_edge;
            done_rowcnt = row_cnt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        done_seen  = 1'b0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        s_edge     = edge_cnt;
    endtask

    // Offer one word until it is accepted; optional start glitch and idle gap.
    task automatic send(input logic [DL-1:0] b, input bit lst, input bit glitch, input bit gap);
        bit hs;
        int n;
        hs = 1'b0;
        n  = 0;
        valid = 1'b1; data = b; last = lst; load_start = glitch;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = ready;
            tick();
            load_start = 1'b0;
            n++;
        end
        valid = 1'b0; last = 1'b0;
        check("send_accepted", 64'(hs), 64'd1);
        if (gap) tick();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done_seen && n < budget) begin
            tick();
            n++;
        end
        check("done_seen", 64'(done_seen), 64'd1);
    endtask

    initial begin
        // Reset state.
        repeat (3) tick();
        @(negedge clk);
        check("rst_state", 64'(state), 64'd0);
        check("rst_addr",  64'(address), 64'd16);
        check("rst_wdata", 64'(wdata), 64'd0);
        tick();
        rst = 1'b0;

        // Valid in IDLE must not be consumed.
        valid = 1'b1; data = 8'hEE;
        repeat (3) tick();
        valid = 1'b0;
        check("idle_no_write", 64'(wlog_addr.size()), 64'd0);

        // Continuous load of 0x01..0x10.
        wlog_addr.delete(); wlog_data.delete();
        pulse_start();
        for (int i = 1; i <= 16; i++) send(8'(i), 1'b0, 1'b0, 1'b0);
        wait_done(20);
        check("c_nwrites", 64'(wlog_addr.size()), 64'd2);
        if (wlog_addr.size() == 2) begin
            check("c_addr0", 64'(wlog_addr[0]), 64'd16);
            check("c_data0", 64'(wlog_data[0]), 64'h0807060504030201);
            check("c_addr1", 64'(wlog_addr[1]), 64'd17);
            check("c_data1", 64'(wlog_data[1]), 64'h100F0E0D0C0B0A09);
        end
        check("c_rowcnt", 64'(done_rowcnt), 64'd2);
        // Two rows of 8 words + 1 write cycle, then the done cycle.
        check("c_latency", 64'(done_diff), 64'd19);

        // Same load with valid toggling, and a stray start mid-FILL.
        wlog_addr.delete(); wlog_data.delete();
        pulse_start();
        for (int i = 1; i <= 16; i++) send(8'(i), 1'b0, i == 4, 1'b1);
        wait_done(40);
        check("t_nwrites", 64'(wlog_addr.size()), 64'd2);
        if (wlog_addr.size() == 2) begin
            check("t_data0", 64'(wlog_data[0]), 64'h0807060504030201);
            check("t_data1", 64'(wlog_data[1]), 64'h100F0E0D0C0B0A09);
        end
        // Each row spans 16 cycles with the gaps; plus the done cycle.
        check("t_latency", 64'(done_diff), 64'd33);
        repeat (3) tick();
        check("t_no_extra", 64'(wlog_addr.size()), 64'd2);

        // Reset after 5 words of the first row; then a fresh load.
        wlog_addr.delete(); wlog_data.delete();
        pulse_start();
        for (int i = 0; i < 5; i++) send(8'($urandom), 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("r_state", 64'(state), 64'd0);
        check("r_rowcnt", 64'(row_cnt), 64'd0);
        check("r_no_write", 64'(wlog_addr.size()), 64'd0);
        tick();
        pulse_start();
        for (int i = 0; i < 16; i++) send(8'($urandom), 1'b0, 1'b0, 1'b0);
        wait_done(20);
        check("r_first_addr", (wlog_addr.size() > 0) ? 64'(wlog_addr[0]) : 64'hDEAD, 64'd16);

        // Early terminator after two words.
        wlog_addr.delete(); wlog_data.delete();
        pulse_start();
        send(8'hAA, 1'b0, 1'b0, 1'b0);
        send(8'hBB, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
`ifdef PACKER_EARLY_LAST_EN
        check("e_nwrites", 64'(wlog_addr.size()), 64'd1);
        check("e_data", (wlog_data.size() > 0) ? 64'(wlog_data[0]) : 64'hDEAD, 64'h000000000000BBAA);
`else
        check("e_nwrites", 64'(wlog_addr.size()), 64'd0);
        for (int i = 1; i <= 6; i++) send(8'(i), 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        check("e_data", (wlog_data.size() > 0) ? 64'(wlog_data[0]) : 64'hDEAD, 64'h060504030201BBAA);
`endif
        for (int i = 0; i < 8; i++) send(8'($urandom), 1'b0, 1'b0, 1'b0);
        wait_done(20);

        // Randomized traffic; the per-cycle compare checks every cycle.
        wlog_addr.delete(); wlog_data.delete();
        for (int c = 0; c < 3000; c++) begin
            valid      = ($urandom % 3) != 0;
            data       = 8'($urandom);
            last       = ($urandom % 5) == 0;
            load_start = ($urandom % 12) == 0;
            rst        = ($urandom % 400) == 0;
            tick();
        end
        valid = 1'b0; last = 1'b0; load_start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rand_wrote", 64'(wlog_addr.size() > 10), 64'd1);

        // Full-size instance: 12 rows at offset 0, continuous stream.
        begin
            int  idx, nb_wr, sb;
            bit  hs, seen;
            logic [ROW-1:0] exp_row;
            idx = 0; nb_wr = 0; seen = 1'b0;
            start_b = 1'b1;
            tick();
            start_b = 1'b0;
            sb = edge_cnt;
            valid_b = 1'b1;
            data_b = 8'd0;
            for (int c = 0; c < 200 && !seen; c++) begin
                @(negedge clk);
                if (wr_en_b) begin
                    exp_row = '0;
                    for (int j = 0; j < MM; j++) exp_row[DL*j +: DL] = 8'(nb_wr * MM + j);
                    check("b_addr", 64'(address_b), 64'(nb_wr));
                    check("b_data", 64'(wdata_b), 64'(exp_row));
                    nb_wr++;
                end
                if (done_b) begin
                    seen = 1'b1;
                    check("b_latency", 64'(edge_cnt + 1 - sb), 64'd109);
                    check("b_rowcnt", 64'(row_cnt_b), 64'd12);
                end
                hs = ready_b;
                tick();
                if (hs) begin
                    idx++;
                    data_b = 8'(idx);
                end
            end
            valid_b = 1'b0;
            check("b_done_seen", 64'(seen), 64'd1);
            check("b_nwrites", 64'(nb_wr), 64'd12);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
